// File: rtl/adc_rx_ctrl.sv
// ADC receive capture controller: frame-lock detection, I/Q pairing and
// length-bounded delivery of pairs over a one-entry valid/ready output register.
module adc_rx_ctrl #(
    parameter int LOCK_CNT = 4,
    parameter int LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      rx_data,
    input  logic             rx_frame,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic [23:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             lock,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_t           state;
    logic [3:0]       alt_cnt;
    logic [3:0]       alt_next;
    logic             prev_frame;
    logic [11:0]      i_hold;
    logic [LEN_W-1:0] remaining;
    logic             pair_ok;
    logic             accept;
    logic             slot_free;

    always_comb begin
        alt_next = 4'd0;
        if (rx_frame != prev_frame)
            alt_next = (alt_cnt == LOCK_MAX) ? alt_cnt : alt_cnt + 4'd1;
    end

    // A pair is the Q sample of this cycle joined to the I sample of the previous one.
    assign pair_ok   = prev_frame && !rx_frame && lock;
    assign accept    = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alt_cnt    <= 4'd0;
            prev_frame <= 1'b0;
            i_hold     <= 12'd0;
            lock       <= 1'b0;
        end else begin
            alt_cnt    <= alt_next;
            prev_frame <= rx_frame;
            lock       <= (alt_next == LOCK_MAX);
            if (rx_frame)
                i_hold <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            out_data  <= 24'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept)
                out_valid <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                remaining <= '0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            remaining <= len;
                            overflow  <= 1'b0;
                            if (len == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= ARM;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ARM: begin
                        if (lock && rx_frame)
                            state <= CAPTURE;
                    end
                    CAPTURE: begin
                        // Losing lock keeps the count and any pending output; only the half pair is lost.
                        if (!lock) begin
                            state <= ARM;
                        end else if (pair_ok) begin
                            if (slot_free) begin
                                out_data  <= {i_hold, rx_data};
                                out_valid <= 1'b1;
                                remaining <= remaining - LEN_ONE;
                                if (remaining == LEN_ONE)
                                    state <= DRAIN;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (slot_free) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_rx_ctrl.sv
// Directed bench for adc_rx_ctrl: a vector table for lock-up and a plain capture,
// then hand-written sequences for overflow, relock, abort and zero-length requests.
module tb_adc_rx_ctrl;

    logic        clk;
    logic        rst_n;
    logic [11:0] rx_data;
    logic        rx_frame;
    logic        start;
    logic [15:0] len;
    logic        abort;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        lock;
    logic        overflow;

    int checks;
    int failures;
    int beats;

    adc_rx_ctrl #(.LOCK_CNT(4), .LEN_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_frame (rx_frame),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .lock     (lock),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && out_valid && out_ready)
            beats++;

    typedef struct {
        logic        f;
        logic [11:0] d;
        logic        st;
        logic [15:0] ln;
        logic        ev;
        logic [23:0] edat;
        logic        eb;
        logic        ed;
        logic        el;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One receive cycle; start/abort are single-cycle pulses.
    task automatic cyc(input logic f, input logic [11:0] d);
        rx_frame = f;
        rx_data  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        beats     = 0;
        rst_n     = 1'b0;
        rx_data   = 12'd0;
        rx_frame  = 1'b0;
        start     = 1'b0;
        len       = 16'd0;
        abort     = 1'b0;
        out_ready = 1'b1;

        //            f     d        st    ln     ev    edat          eb    ed    el
        tbl[0]  = '{1'b1, 12'h000, 1'b0, 16'd0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 12'h000, 1'b0, 16'd0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 12'h000, 1'b0, 16'd0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 12'h000, 1'b0, 16'd0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 12'h111, 1'b1, 16'd3, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 12'h222, 1'b0, 16'd0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 12'h123, 1'b0, 16'd0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 12'h456, 1'b0, 16'd0, 1'b1, 24'h123456, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 12'h124, 1'b0, 16'd0, 1'b0, 24'h123456, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 12'h457, 1'b0, 16'd0, 1'b1, 24'h124457, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 12'h125, 1'b0, 16'd0, 1'b0, 24'h124457, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 12'h458, 1'b0, 16'd0, 1'b1, 24'h125458, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 12'h126, 1'b0, 16'd0, 1'b0, 24'h125458, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 12'h459, 1'b0, 16'd0, 1'b0, 24'h125458, 1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {8'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_lock", {31'd0, lock}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;

        // Lock-up followed by a len=3 capture with the consumer always ready.
        beats = 0;
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].st;
            len   = tbl[i].ln;
            cyc(tbl[i].f, tbl[i].d);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d_data", i), {8'd0, out_data}, {8'd0, tbl[i].edat});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].eb});
            chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, tbl[i].ed});
            chk($sformatf("vec%0d_lock", i), {31'd0, lock}, {31'd0, tbl[i].el});
            chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, 32'd0);
        end
        chk("len3_beats", beats, 32'd3);

        // Stalled consumer, len=2: first pair held, second dropped, third loads on the accept edge.
        out_ready = 1'b0;
        start = 1'b1; len = 16'd2;
        cyc(1'b1, 12'h200);
        cyc(1'b0, 12'h300);
        cyc(1'b1, 12'h201);
        cyc(1'b0, 12'h301);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {8'd0, out_data}, 32'h00201301);
        cyc(1'b1, 12'h202);
        cyc(1'b0, 12'h302);
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
        chk("drop_data_held", {8'd0, out_data}, 32'h00201301);
        chk("drop_busy", {31'd0, busy}, 32'd1);
        cyc(1'b1, 12'h203);
        out_ready = 1'b1;
        cyc(1'b0, 12'h303);
        chk("samedge_valid", {31'd0, out_valid}, 32'd1);
        chk("samedge_data", {8'd0, out_data}, 32'h00203303);
        chk("samedge_busy", {31'd0, busy}, 32'd1);
        cyc(1'b1, 12'h204);
        chk("stall_done", {31'd0, done}, 32'd1);
        chk("stall_busy_fall", {31'd0, busy}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        cyc(1'b0, 12'h304);

        // Frame repeat mid-capture, len=4: relock and finish the remaining pairs.
        beats = 0;
        start = 1'b1; len = 16'd4;
        cyc(1'b1, 12'h400);
        chk("start_clears_ovf", {31'd0, overflow}, 32'd0);
        cyc(1'b0, 12'h500);
        cyc(1'b1, 12'h401);
        cyc(1'b0, 12'h501);
        chk("rl_first", {8'd0, out_data}, 32'h00401501);
        cyc(1'b1, 12'h402);
        cyc(1'b0, 12'h502);
        chk("rl_second", {8'd0, out_data}, 32'h00402502);
        cyc(1'b1, 12'h403);
        cyc(1'b1, 12'h404);
        chk("rl_lock_drop", {31'd0, lock}, 32'd0);
        cyc(1'b0, 12'h504);
        chk("rl_no_pair", {31'd0, out_valid}, 32'd0);
        chk("rl_busy", {31'd0, busy}, 32'd1);
        cyc(1'b1, 12'h0AA);
        cyc(1'b0, 12'h0BB);
        cyc(1'b1, 12'h0CC);
        chk("rl_relock", {31'd0, lock}, 32'd1);
        cyc(1'b0, 12'h0DD);
        chk("rl_arm_idle", {31'd0, out_valid}, 32'd0);
        cyc(1'b1, 12'h405);
        cyc(1'b0, 12'h505);
        chk("rl_third", {8'd0, out_data}, 32'h00405505);
        cyc(1'b1, 12'h406);
        cyc(1'b0, 12'h506);
        chk("rl_fourth", {8'd0, out_data}, 32'h00406506);
        cyc(1'b1, 12'h407);
        chk("rl_done", {31'd0, done}, 32'd1);
        chk("rl_beats", beats, 32'd4);
        cyc(1'b0, 12'h000);

        // Abort with a pending pair and a dropped pair.
        start = 1'b1; len = 16'd2;
        cyc(1'b1, 12'h600);
        cyc(1'b0, 12'h700);
        out_ready = 1'b0;
        cyc(1'b1, 12'h601);
        cyc(1'b0, 12'h701);
        chk("ab_valid", {31'd0, out_valid}, 32'd1);
        cyc(1'b1, 12'h602);
        cyc(1'b0, 12'h702);
        chk("ab_ovf_set", {31'd0, overflow}, 32'd1);
        abort = 1'b1;
        cyc(1'b1, 12'h603);
        chk("ab_valid_clr", {31'd0, out_valid}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_no_done", {31'd0, done}, 32'd0);
        chk("ab_ovf_kept", {31'd0, overflow}, 32'd1);
        out_ready = 1'b1;
        cyc(1'b0, 12'h703);
        chk("ab_no_done2", {31'd0, done}, 32'd0);
        chk("ab_still_idle", {31'd0, busy}, 32'd0);

        // Zero-length request, then a start while busy that must be ignored.
        beats = 0;
        start = 1'b1; len = 16'd0;
        cyc(1'b1, 12'h800);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_busy", {31'd0, busy}, 32'd0);
        chk("z_ovf_clr", {31'd0, overflow}, 32'd0);
        cyc(1'b0, 12'h900);
        chk("z_done_pulse", {31'd0, done}, 32'd0);
        chk("z_beats", beats, 32'd0);
        start = 1'b1; len = 16'd2;
        cyc(1'b1, 12'h801);
        cyc(1'b0, 12'h901);
        start = 1'b1; len = 16'd9;
        cyc(1'b1, 12'h802);
        cyc(1'b0, 12'h902);
        chk("ig_first", {8'd0, out_data}, 32'h00802902);
        cyc(1'b1, 12'h803);
        cyc(1'b0, 12'h903);
        chk("ig_second", {8'd0, out_data}, 32'h00803903);
        cyc(1'b1, 12'h804);
        chk("ig_done", {31'd0, done}, 32'd1);
        chk("ig_beats", beats, 32'd2);
        cyc(1'b0, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_rx_ctrl.md
# adc_rx_ctrl

Capture controller for the ADC receive path. It sits downstream of the LVDS/IDDR receiver, in the receiver's clock domain. It qualifies the framed 12-bit sample stream: frame lock detection, then I/Q pairing. On command it delivers exactly `len` I/Q pairs over a valid/ready interface, reporting completion and dropped samples.

## Interface
- `LOCK_CNT`, 4: consecutive alternating frame samples required to declare lock (2..15).
- `LEN_W`, 16: width of the pair-count request.
- `clk` input 1: receive clock (the receiver's regional clock); all logic on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_data` input 12: sample word from the receiver, new word every cycle.
- `rx_frame` input 1: frame bit aligned with `rx_data`; 1 = I sample, 0 = Q sample.
- `start` input 1: one-cycle capture request, honoured only in IDLE.
- `len` input LEN_W: number of I/Q pairs to capture, sampled with `start`.
- `abort` input 1: terminate capture immediately, any state.
- `out_data` output 24: {I[11:0], Q[11:0]}.
- `out_valid` output 1: `out_data` holds an undelivered pair.
- `out_ready` input 1: consumer accepts when `out_valid && out_ready`.
- `busy` output 1: state != IDLE.
- `done` output 1: one-cycle pulse when a capture completes normally.
- `lock` output 1: frame lock status.
- `overflow` output 1: sticky; a completed pair was dropped.

## Operation
- Lock detector runs continuously, independent of FSM. Alternation counter (4 bits, saturating at LOCK_CNT) increments when `rx_frame` != previous `rx_frame`. It clears to 0 on any repeat. `lock` = counter == LOCK_CNT.
- Pairing: I register loaded when `rx_frame`=1; a pair completes on the following cycle if `rx_frame`=0 and lock is held. Q without a preceding I in the previous cycle is ignored.
- FSM states: IDLE, ARM, CAPTURE, DRAIN.
  - IDLE: `start` latches `len` into the remaining counter and clears `overflow`. `len`=0 -> stay IDLE, `done` pulses next cycle. Otherwise -> ARM.
  - ARM: wait for `lock`=1 and `rx_frame`=1 in the same cycle. That I sample is the first captured; -> CAPTURE.
  - CAPTURE: each completed pair is loaded into the output register if it is empty or being accepted this cycle. Then the remaining count decrements; count reaching 0 -> DRAIN. If the output register is full and not accepted, the pair is dropped: `overflow` <= 1, count unchanged.
  - Lock lost in CAPTURE -> ARM. Half-formed pair discarded; remaining count and output register preserved.
  - DRAIN: wait until the output register is empty (or accepted this cycle). Then -> IDLE with `done`=1 for one cycle.
- `abort` (highest priority, any state): -> IDLE, `out_valid` <= 0, counter cleared, no `done`, `overflow` retained.
- `start` outside IDLE is ignored.
- Output register is one entry. `out_data` holds its value while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `lock`=0, `overflow`=0. FSM is in IDLE, alternation counter 0, I register 0.
- Lock: `lock` rises on the edge registering the LOCK_CNT-th alternation. It falls on the edge registering the first repeat.
- Latency: `out_valid` rises on the edge after the Q sample is presented, i.e. 1 cycle after the Q cycle, 2 after the I cycle.
- Sustained rate: one pair per 2 cycles. `out_ready` held 1 -> no overflow.
- Same-edge accept and new pair: accept wins. The new pair loads, `out_valid` stays 1, and there is no overflow.
- `busy` rises the cycle after `start`. It falls the same edge `done` rises.

## Test plan
- Reset then alternating frame 1,0,1,0...: `lock`=0 for the first 4 alternations, 1 afterwards; all outputs at reset values until `start`.
- Locked, `out_ready`=1, `start` with `len`=3, I=0x123/Q=0x456 incrementing: exactly 3 beats 0x123456, 0x124457, 0x125458. `done` pulses once; `overflow`=0.
- `out_ready`=0 with `len`=2: first pair held stable, second pair dropped and `overflow`=1. FSM stays in CAPTURE until a third pair is accepted.
- Frame repeat (1,1) mid-capture with `len`=4: `lock` drops, no pair emitted from the corrupt cycle. After relock, remaining pairs are delivered; 4 total, then `done`.
- `abort` while `out_valid`=1 in CAPTURE: next cycle `out_valid`=0, `busy`=0, no `done`.
- `start` with `len`=0: `done` pulses next cycle, no beats. `start` while busy: ignored, count unchanged.
